gaussian_writer: RTL
====================

// Module: gaussian_writer
//
// PURPOSE
// Downstream stage of the gaussian filter datapath. Consumes the 128-bit
// (16 x 8-bit pixel) result beats produced each valid cycle by the filter unit.
// Discards the row-buffer warm-up beats, buffers the remaining beats in a FIFO
// and issues them as addressed line writes on a valid/ready write channel.
// Throttles the upstream pipeline via an almost-full flag.
//
// PARAMETERS
// DATA_W       128  beat/line width in bits (16 pixels)
// ADDR_W       42   line-granular write address width
// FIFO_DEPTH   16   result FIFO entries (power of 2)
// AFULL_THRESH 12   occupancy at/above which in_afull asserts
// SKIP_W       16   width of the warm-up skip counter
//
// PORTS
// clk         input   1        clock
// rst         input   1        reset, asynchronous, active-high
// start       input   1        1-cycle pulse; latches config (honoured in IDLE only)
// base_addr   input   ADDR_W   first output line address
// num_lines   input   32       beats to write after skip
// skip_lines  input   SKIP_W   leading warm-up beats to discard
// in_valid    input   1        filter result beat valid
// in_data     input   DATA_W   filter result beat
// in_afull    output  1        FIFO occupancy >= AFULL_THRESH
// wr_valid    output  1        write request valid
// wr_addr     output  ADDR_W   write line address
// wr_data     output  DATA_W   write line data
// wr_ready    input   1        write channel accepts when wr_valid&&wr_ready
// busy        output  1        state != IDLE
// done        output  1        1-cycle pulse when the final write is accepted
// overflow    output  1        sticky: beat arrived while FIFO full and no pop
//
// BEHAVIOUR
// - Async reset: all outputs 0, FIFO emptied, counters 0, state IDLE.
//   Reset mid-operation aborts; buffered data is lost.
// - FSM: IDLE -start-> SKIP (or STREAM if skip_lines==0).
//   SKIP: each in_valid beat is dropped; after skip_lines beats -> STREAM.
//   STREAM: each in_valid beat is pushed; after num_lines beats pushed -> DRAIN.
//   num_lines==0 -> DRAIN immediately.
//   DRAIN: wait FIFO empty and no pending write -> DONE.
//   DONE: done=1 for one cycle -> IDLE.
// - start outside IDLE is ignored. in_valid in IDLE/DRAIN/DONE is ignored.
// - Push occurs on the same edge as in_valid. wr_valid rises the next cycle
//   at the earliest (registered FIFO head).
// - wr_addr/wr_data are held stable while wr_valid && !wr_ready.
// - wr_addr = base_addr + write index, modulo 2^ADDR_W (wraps silently).
// - Full FIFO with a same-cycle pop: the push is accepted (count unchanged).
//   Full FIFO without a pop: the beat is dropped and overflow is set (sticky
//   until rst or the next accepted start). Dropped beats still count toward
//   num_lines.
// - in_afull is combinational on the registered occupancy.
//   Upstream stops asserting in_valid within 4 cycles of it.
//
// CONFIGURATION
// GAUSSIAN_WRITER_STALL_CNT_EN defined:
//   - adds output stall_cycles[31:0], counting cycles with wr_valid && !wr_ready
//   - cleared on accepted start; saturates at 2^32-1
// Undefined: port and counter are absent; behaviour is otherwise identical.
//
// TESTING
// 1. skip=2, num=4, wr_ready=1, beats 0..5 -> writes data 2,3,4,5 at
//    base..base+3, done pulses once, busy drops next cycle.
// 2. wr_ready=0, 12 beats -> in_afull=1 after the 12th push.
//    wr_data/wr_addr are stable until wr_ready=1.
// 3. wr_ready=0, skip=0, num=17, 17 beats -> overflow=1, 16 writes issued,
//    done still pulses.
// 4. base=2^42-2, num=4 -> wr_addr sequence 2^42-2, 2^42-1, 0, 1.
// 5. rst asserted after 3 accepted writes -> wr_valid=0, busy=0 immediately.
//    A new start runs case 1 correctly.
// 6. start pulsed while busy is ignored; skip=0, num=0 -> done pulse within
//    3 cycles of start, no writes.

Source files
------------

// File: rtl/gaussian_writer.sv
`default_nettype none
// ============================================================================
// Module   : gaussian_writer
// Brief    : Output stage of the gaussian filter datapath. Drops row-buffer
//            warm-up beats, buffers result beats in a FIFO and issues them as
//            addressed line writes on a valid/ready channel.
// Options  : GAUSSIAN_WRITER_STALL_CNT_EN adds the stall_cycles counter port.
// Revision : 1.0 - initial release
// ============================================================================
module gaussian_writer #(
  parameter int DATA_W       = 128,
  parameter int ADDR_W       = 42,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_THRESH = 12,
  parameter int SKIP_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       num_lines,
  input  logic [SKIP_W-1:0] skip_lines,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_afull,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef GAUSSIAN_WRITER_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int                 c_PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]   c_DEPTH    = (c_PTR_W+1)'(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]   c_AFULL    = (c_PTR_W+1)'(AFULL_THRESH);
  localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W+1)'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [SKIP_W-1:0]  c_SKIP_ONE = SKIP_W'(1);
  localparam logic [ADDR_W-1:0]  c_ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SKIP   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-1:0]   r_base;
  logic [31:0]         r_num;
  logic [SKIP_W-1:0]   r_skip;
  logic [SKIP_W-1:0]   r_skip_cnt;
  logic [31:0]         r_beat_cnt;
  logic [ADDR_W-1:0]   r_wr_idx;
  logic                r_overflow;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wptr;
  logic [c_PTR_W-1:0]  r_rptr;
  logic [c_PTR_W:0]    r_count;

  logic w_start_ok;
  logic w_head_valid;
  logic w_pop;
  logic w_full;
  logic w_beat;
  logic w_push;
  logic w_drop;
  logic w_skip_beat;
  logic w_skip_last;
  logic w_stream_last;

  assign w_start_ok    = start && (r_state == S_IDLE);
  assign w_head_valid  = (r_count != '0);
  assign w_pop         = w_head_valid && wr_ready;
  assign w_full        = (r_count == c_DEPTH);
  assign w_beat        = in_valid && (r_state == S_STREAM);
  // A full FIFO still takes the beat if the head leaves on the same edge.
  assign w_push        = w_beat && (!w_full || w_pop);
  assign w_drop        = w_beat && w_full && !w_pop;
  assign w_skip_beat   = in_valid && (r_state == S_SKIP);
  assign w_skip_last   = w_skip_beat && (r_skip_cnt == (r_skip - c_SKIP_ONE));
  assign w_stream_last = w_beat && (r_beat_cnt == (r_num - 32'd1));

  // The head entry is the write request; zeroed when idle so outputs are clean.
  assign wr_valid = w_head_valid;
  assign wr_data  = w_head_valid ? r_mem[r_rptr] : '0;
  assign wr_addr  = w_head_valid ? (r_base + r_wr_idx) : '0;
  assign in_afull = (r_count >= c_AFULL);
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign overflow = r_overflow;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; zero-length phases are bypassed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (skip_lines != '0)     w_state_nxt = S_SKIP;
          else if (num_lines != '0) w_state_nxt = S_STREAM;
          else                      w_state_nxt = S_DRAIN;
        end
      end
      S_SKIP:   if (w_skip_last)   w_state_nxt = (r_num != '0) ? S_STREAM : S_DRAIN;
      S_STREAM: if (w_stream_last) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (r_count == '0) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Job configuration, phase counters, write index and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base     <= '0;
      r_num      <= '0;
      r_skip     <= '0;
      r_skip_cnt <= '0;
      r_beat_cnt <= '0;
      r_wr_idx   <= '0;
      r_overflow <= 1'b0;
    end else if (w_start_ok) begin
      r_base     <= base_addr;
      r_num      <= num_lines;
      r_skip     <= skip_lines;
      r_skip_cnt <= '0;
      r_beat_cnt <= '0;
      r_wr_idx   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_skip_beat) r_skip_cnt <= w_skip_last ? '0 : (r_skip_cnt + c_SKIP_ONE);
      // Dropped beats still advance the line count.
      if (w_beat)      r_beat_cnt <= r_beat_cnt + 32'd1;
      if (w_pop)       r_wr_idx   <= r_wr_idx + c_ADDR_ONE;
      if (w_drop)      r_overflow <= 1'b1;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are qualified by the occupancy so need no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

`ifdef GAUSSIAN_WRITER_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  assign stall_cycles = r_stall_cnt;

  // Saturating count of cycles where a write is offered but not taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               r_stall_cnt <= '0;
    else if (w_start_ok)                                   r_stall_cnt <= '0;
    else if (w_head_valid && !wr_ready && (r_stall_cnt != 32'hFFFF_FFFF))
                                                           r_stall_cnt <= r_stall_cnt + 32'd1;
  end
`endif

endmodule
`default_nettype wire
